// File: rtl/mem_sram.sv
// Single-port synchronous RAM with registered read data and an illegal-access pulse.
// Define MEM_PARITY_EN to add per-word even-parity storage and the par_err output.
module mem_sram #(
    parameter  int DEPTH = 32,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             read,
    input  logic             write,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
`ifdef MEM_PARITY_EN
    output logic             par_err,
`endif
    output logic             rw_err
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             rw_err_q, rw_err_d;
    logic             in_range;
    logic             wr_en;
    logic             rd_en;

    always_comb begin
        in_range   = int'(addr) < DEPTH;
        wr_en      = write && !read && in_range;
        rd_en      = read && !write;
        // Out-of-range only counts as illegal when an access is actually attempted.
        rw_err_d   = (read && write) || ((read || write) && !in_range);
        data_out_d = data_out_q;
        if (rd_en) begin
            data_out_d = in_range ? mem_q[addr] : '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data_out_q <= '0;
            rw_err_q   <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[addr] <= data_in;
            end
            data_out_q <= data_out_d;
            rw_err_q   <= rw_err_d;
        end
    end

    assign data_out = data_out_q;
    assign rw_err   = rw_err_q;

`ifdef MEM_PARITY_EN
    logic par_q [DEPTH];
    logic par_err_q, par_err_d;

    always_comb begin
        par_err_d = par_err_q;
        if (rd_en) begin
            par_err_d = in_range ? ((^mem_q[addr]) != par_q[addr]) : 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                par_q[i] <= 1'b0;
            end
            par_err_q <= 1'b0;
        end else begin
            if (wr_en) begin
                par_q[addr] <= ^data_in;
            end
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;
`endif

endmodule

// File: tb/tb_mem_sram.sv
// Scoreboard bench for mem_sram: driver pushes model expectations, monitor pops and compares.
module tb_mem_sram;

    localparam int DEPTH = 32;
    localparam int WIDTH = 8;
    localparam int AW    = 5;

    logic             clk;
    logic             rst;
    logic             read;
    logic             write;
    logic [AW-1:0]    addr;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             rw_err;
`ifdef MEM_PARITY_EN
    logic             par_err;
`endif

    mem_sram #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .read     (read),
        .write    (write),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out),
`ifdef MEM_PARITY_EN
        .par_err  (par_err),
`endif
        .rw_err   (rw_err)
    );

    typedef struct packed {
        logic [WIDTH-1:0] dout;
        logic             err;
        int unsigned      id;
    } exp_t;

    exp_t             exp_q[$];
    logic [WIDTH-1:0] ref_mem [DEPTH];
    logic [WIDTH-1:0] ref_dout;
    int unsigned      n_vec;
    int unsigned      n_bad;
    int unsigned      txn_id;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        ref_dout = '0;
    endtask

    // One clock of stimulus; the reference model decides the expected outputs.
    task automatic issue(input bit rd, input bit wr, input int a, input logic [WIDTH-1:0] d);
        exp_t e;
        @(negedge clk);
        read    = rd;
        write   = wr;
        addr    = AW'(a);
        data_in = d;
        e.err   = 1'b0;
        if (rd && wr) begin
            e.err = 1'b1;
        end else if (a >= DEPTH) begin
            e.err = rd || wr;
            if (rd) ref_dout = '0;
        end else begin
            if (wr) ref_mem[a] = d;
            if (rd) ref_dout = ref_mem[a];
        end
        e.dout = ref_dout;
        e.id   = txn_id++;
        exp_q.push_back(e);
    endtask

    // Monitor: every clock that has a pending expectation is compared after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (data_out !== e.dout || rw_err !== e.err) begin
                    n_bad++;
                    $display("FAIL txn %0d: data_out=%0h rw_err=%0b, expected data_out=%0h rw_err=%0b",
                             e.id, data_out, rw_err, e.dout, e.err);
                end
`ifdef MEM_PARITY_EN
                check("par_err", {31'b0, par_err}, 32'h0);
`endif
            end
        end
    end

    task automatic drain();
        int unsigned guard;
        guard = 0;
        @(negedge clk);
        read  = 1'b0;
        write = 1'b0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin
        n_vec   = 0;
        n_bad   = 0;
        txn_id  = 0;
        rst     = 1'b0;
        read    = 1'b0;
        write   = 1'b0;
        addr    = '0;
        data_in = '0;
        model_reset();

        #1 rst = 1'b1;
        #1;
        check("reset_dout_immediate", {24'b0, data_out}, 32'h0);
        check("reset_err_immediate", {31'b0, rw_err}, 32'h0);
        @(posedge clk); #1;
        check("reset_dout_held", {24'b0, data_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) issue(1, 0, i, 8'h00);

        issue(0, 1, 5, 8'hA5);
        issue(1, 0, 5, 8'h00);

        issue(0, 1, 0, 8'h11);
        issue(0, 1, 31, 8'hEE);
        issue(1, 0, 0, 8'h00);
        issue(1, 0, 31, 8'h00);
        issue(1, 0, 1, 8'h00);
        issue(1, 0, 30, 8'h00);

        issue(0, 1, 3, 8'h3C);
        issue(1, 0, 3, 8'h00);
        issue(1, 1, 3, 8'hFF);
        issue(0, 0, 3, 8'h00);
        issue(1, 0, 3, 8'h00);

        issue(0, 1, 7, 8'h77);
        issue(1, 0, 7, 8'h00);
        drain();

        // Reset lands between the read being presented and its clock edge.
        issue(0, 1, 7, 8'h77);
        drain();
        @(negedge clk);
        read  = 1'b1;
        write = 1'b0;
        addr  = 5'd7;
        #2 rst = 1'b1;
        #1;
        check("midread_reset_dout", {24'b0, data_out}, 32'h0);
        check("midread_reset_err", {31'b0, rw_err}, 32'h0);
        @(posedge clk); #1;
        check("midread_reset_held", {24'b0, data_out}, 32'h0);
        @(negedge clk);
        rst  = 1'b0;
        read = 1'b0;
        model_reset();
        issue(1, 0, 7, 8'h00);

        for (int n = 0; n < 500; n++) begin
            int unsigned kind;
            kind = $urandom_range(0, 9);
            issue(kind < 4 || kind == 9, (kind >= 4 && kind < 8) || kind == 9,
                  int'($urandom_range(0, DEPTH - 1)), WIDTH'($urandom));
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
